// File: rtl/fetch_stage.sv
// Fetch stage of the MIPS pipeline: the PC register, the instruction-memory
// address, next-PC selection from the D-stage npcOp, and the F/D register.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_3000,
  parameter int          IM_AW   = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_data,
  input  logic [2:0]       d_npc_op,
  input  logic             d_br_taken,
  input  logic [31:0]      d_pc,
  input  logic [15:0]      d_imm16,
  input  logic [25:0]      d_imm26,
  input  logic [31:0]      d_rs_val,
  output logic [31:0]      f_pc,
  output logic [31:0]      fd_instr,
  output logic [31:0]      fd_pc
);

  localparam logic [2:0] NPC_DEFAULT = 3'd0;
  localparam logic [2:0] NPC_B       = 3'd1;
  localparam logic [2:0] NPC_J       = 3'd2;
  localparam logic [2:0] NPC_JR      = 3'd3;

  logic        [31:0] pc;
  logic        [31:0] pc_plus4;
  logic        [31:0] d_pc_plus4;
  logic signed [31:0] br_off;
  logic        [31:0] br_target;
  logic        [31:0] j_target;
  logic        [31:0] npc;

  assign f_pc    = pc;
  assign im_addr = IM_AW'((pc - PC_INIT) >> 2);

  // Targets are relative to the delay-slot address of the instr in D.
  assign pc_plus4   = pc + 32'd4;
  assign d_pc_plus4 = d_pc + 32'd4;
  assign br_off     = {{14{d_imm16[15]}}, d_imm16, 2'b00};
  assign br_target  = d_pc_plus4 + $unsigned(br_off);
  assign j_target   = {d_pc_plus4[31:28], d_imm26, 2'b00};

  always_comb begin
    npc = pc_plus4;
    case (d_npc_op)
      NPC_DEFAULT: npc = pc_plus4;
      NPC_B:       npc = d_br_taken ? br_target : pc_plus4;
      NPC_J:       npc = j_target;
      NPC_JR:      npc = d_rs_val;
      default:     npc = pc_plus4;
    endcase
  end

  // F -> F/D boundary; a stall freezes the PC and the F/D register together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= PC_INIT;
      fd_instr <= 32'h0000_0000;
      fd_pc    <= 32'h0000_0000;
    end else if (!stall) begin
      pc       <= npc;
      fd_instr <= im_data;
      fd_pc    <= pc;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a combinational ROM model
// whose data word encodes its own address.
module tb_fetch_stage;

  localparam logic [2:0] OP_DEF = 3'd0;
  localparam logic [2:0] OP_B   = 3'd1;
  localparam logic [2:0] OP_J   = 3'd2;
  localparam logic [2:0] OP_JR  = 3'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [11:0] im_addr;
  logic [31:0] im_data;
  logic [2:0]  d_npc_op;
  logic        d_br_taken;
  logic [31:0] d_pc;
  logic [15:0] d_imm16;
  logic [25:0] d_imm26;
  logic [31:0] d_rs_val;
  logic [31:0] f_pc;
  logic [31:0] fd_instr;
  logic [31:0] fd_pc;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.PC_INIT(32'h0000_3000), .IM_AW(12)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .im_addr(im_addr), .im_data(im_data),
    .d_npc_op(d_npc_op), .d_br_taken(d_br_taken), .d_pc(d_pc),
    .d_imm16(d_imm16), .d_imm26(d_imm26), .d_rs_val(d_rs_val),
    .f_pc(f_pc), .fd_instr(fd_instr), .fd_pc(fd_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [11:0] a);
    return 32'hC0DE_0000 | {20'h0, a};
  endfunction

  function automatic logic [11:0] addr_of(input logic [31:0] p);
    logic [31:0] w;
    w = (p - 32'h0000_3000) >> 2;
    return w[11:0];
  endfunction

  assign im_data = rom(im_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] e_pc,
                           input logic [31:0] e_fdpc, input logic [31:0] e_fdinstr);
    chk({tag, " f_pc"}, f_pc, e_pc);
    chk({tag, " im_addr"}, {20'h0, im_addr}, {20'h0, addr_of(e_pc)});
    chk({tag, " fd_pc"}, fd_pc, e_fdpc);
    chk({tag, " fd_instr"}, fd_instr, e_fdinstr);
  endtask

  task automatic drive(input logic s, input logic [2:0] op, input logic tk,
                       input logic [31:0] dpc, input logic [15:0] i16,
                       input logic [25:0] i26, input logic [31:0] rs);
    stall = s; d_npc_op = op; d_br_taken = tk; d_pc = dpc;
    d_imm16 = i16; d_imm26 = i26; d_rs_val = rs;
  endtask

  typedef struct {
    logic        stall;
    logic [2:0]  op;
    logic        tk;
    logic [31:0] dpc;
    logic [15:0] i16;
    logic [25:0] i26;
    logic [31:0] rs;
    logic [31:0] e_pc;
    logic [31:0] e_fdpc;
    logic [11:0] e_fdaddr;
  } vec_t;

  vec_t vecs[18];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b0, OP_DEF, 1'b0, 32'h0,    16'h0,    26'h0,   32'h0,         32'h3004,      32'h3000,      12'h000};
    vecs[1]  = '{1'b0, OP_DEF, 1'b0, 32'h0,    16'h0,    26'h0,   32'h0,         32'h3008,      32'h3004,      12'h001};
    vecs[2]  = '{1'b0, OP_B,   1'b1, 32'h3004, 16'hFFFF, 26'h0,   32'h0,         32'h3004,      32'h3008,      12'h002};
    vecs[3]  = '{1'b0, OP_DEF, 1'b0, 32'h0,    16'h0,    26'h0,   32'h0,         32'h3008,      32'h3004,      12'h001};
    vecs[4]  = '{1'b0, OP_B,   1'b0, 32'h3004, 16'hFFFF, 26'h0,   32'h0,         32'h300C,      32'h3008,      12'h002};
    vecs[5]  = '{1'b0, OP_DEF, 1'b0, 32'h0,    16'h0,    26'h0,   32'h0,         32'h3010,      32'h300C,      12'h003};
    vecs[6]  = '{1'b0, OP_DEF, 1'b0, 32'h0,    16'h0,    26'h0,   32'h0,         32'h3014,      32'h3010,      12'h004};
    vecs[7]  = '{1'b0, OP_J,   1'b0, 32'h3010, 16'h0,    26'hC10, 32'h0,         32'h3040,      32'h3014,      12'h005};
    vecs[8]  = '{1'b0, OP_DEF, 1'b0, 32'h0,    16'h0,    26'h0,   32'h0,         32'h3044,      32'h3040,      12'h010};
    vecs[9]  = '{1'b0, OP_JR,  1'b0, 32'h0,    16'h0,    26'h0,   32'h3100,      32'h3100,      32'h3044,      12'h011};
    vecs[10] = '{1'b0, OP_JR,  1'b0, 32'h0,    16'h0,    26'h0,   32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h3100,      12'h040};
    vecs[11] = '{1'b0, OP_DEF, 1'b0, 32'h0,    16'h0,    26'h0,   32'h0,         32'h0000_0000, 32'hFFFF_FFFC, 12'h3FF};
    vecs[12] = '{1'b0, OP_DEF, 1'b0, 32'h0,    16'h0,    26'h0,   32'h0,         32'h0000_0004, 32'h0000_0000, 12'h400};
    vecs[13] = '{1'b1, OP_J,   1'b0, 32'h3010, 16'h0,    26'hC10, 32'h0,         32'h0000_0004, 32'h0000_0000, 12'h400};
    vecs[14] = '{1'b1, OP_J,   1'b0, 32'h3010, 16'h0,    26'hC10, 32'h0,         32'h0000_0004, 32'h0000_0000, 12'h400};
    vecs[15] = '{1'b0, OP_J,   1'b0, 32'h3010, 16'h0,    26'hC10, 32'h0,         32'h3040,      32'h0000_0004, 12'h401};
    vecs[16] = '{1'b0, 3'd5,   1'b1, 32'h3010, 16'h0010, 26'h0,   32'h0,         32'h3044,      32'h3040,      12'h010};
    vecs[17] = '{1'b1, OP_B,   1'b1, 32'h3040, 16'h0010, 26'h0,   32'h0,         32'h3044,      32'h3040,      12'h010};

    drive(1'b0, OP_DEF, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
    rst_n = 1'b0;
    #12;
    chk_state("reset", 32'h3000, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].stall, vecs[i].op, vecs[i].tk, vecs[i].dpc,
            vecs[i].i16, vecs[i].i26, vecs[i].rs);
      @(posedge clk);
      #1;
      chk_state($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_fdpc, rom(vecs[i].e_fdaddr));
    end

    // Asynchronous reset between edges while a stall and a redirect are pending.
    drive(1'b1, OP_JR, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0000_5000);
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("midreset", 32'h3000, 32'h0, 32'h0);
    drive(1'b0, OP_DEF, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk_state($sformatf("resume%0d", k), 32'h3004 + 32'(4 * k),
                32'h3000 + 32'(4 * k), rom(12'(k)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
